// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg -- shared types and constants for the stream demultiplexer.
//   state_t        : EMPTY / FULL state of the single output register.
//   DEFAULT_WIDTH  : default data width in bits.
//   DEFAULT_N      : default number of downstream channels.
package stream_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_N     = 4;

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if -- upstream/downstream handshake bundle of stream_demux.
//   up_valid/up_data/up_sel/up_ready : single upstream stream with destination index.
//   dn_valid (one-hot)/dn_data/dn_ready : N downstream channels sharing one data bus.
//   sel_err   : one-cycle pulse for a word dropped because of an out-of-range index.
//   dbg_state : current EMPTY/FULL state, for observation only.
// Handshake: a word moves across an interface exactly on a cycle where valid and
// ready are both high at the rising clock edge; valid never depends on ready.
// Modports: slave = the demux itself, master = the environment around it.
interface stream_demux_if #(
  parameter int WIDTH = stream_demux_pkg::DEFAULT_WIDTH,
  parameter int N     = stream_demux_pkg::DEFAULT_N
);
  logic                         up_valid;
  logic [WIDTH-1:0]             up_data;
  logic [$clog2(N)-1:0]         up_sel;
  logic                         up_ready;
  logic [N-1:0]                 dn_valid;
  logic [WIDTH-1:0]             dn_data;
  logic [N-1:0]                 dn_ready;
  logic                         sel_err;
  stream_demux_pkg::state_t     dbg_state;

  modport slave (
    input  up_valid, up_data, up_sel, dn_ready,
    output up_ready, dn_valid, dn_data, sel_err, dbg_state
  );

  modport master (
    output up_valid, up_data, up_sel, dn_ready,
    input  up_ready, dn_valid, dn_data, sel_err, dbg_state
  );
endinterface

// File: rtl/stream_demux_rr_pointer.sv
// rr_pointer -- modulo-N counter selecting the next destination channel.
//   clk : clock, rising edge.
//   rst : asynchronous active-high reset, clears ptr to 0.
//   inc : advance the pointer by one (wrapping N-1 -> 0).
//   ptr : current channel index.
module rr_pointer #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] ptr
);
  localparam int PW = $clog2(N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: rtl/stream_demux.sv
// stream_demux -- routes one upstream stream to one of N downstream channels
// through a single output register (EMPTY/FULL), sustaining one word per cycle.
//   clk : clock, rising edge.
//   rst : asynchronous active-high reset; drops any held word.
//   bus : stream_demux_if.slave (upstream, downstream, sel_err, dbg_state).
// Optional feature: define STREAM_DEMUX_RR_EN to ignore up_sel and route words
// round-robin from an internal pointer; sel_err is then always 0.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  stream_demux_if.slave  bus
);
  localparam int SELW = $clog2(N);

  state_t            state;
  logic [WIDTH-1:0]  data_q;
  logic [SELW-1:0]   dest_q;
  logic              sel_err_q;

  logic [SELW-1:0]   new_dest;
  logic              sel_bad;
  logic              up_ready;
  logic              up_xfer;
  logic              dn_xfer;

  // Accept when empty, or when the held word leaves this same cycle.
  assign up_ready = (state == EMPTY) || bus.dn_ready[dest_q];
  assign up_xfer  = bus.up_valid && up_ready;
  assign dn_xfer  = (state == FULL) && bus.dn_ready[dest_q];

`ifdef STREAM_DEMUX_RR_EN
  logic [SELW-1:0] rr_ptr;

  rr_pointer #(.N(N)) u_rr_pointer (
    .clk (clk),
    .rst (rst),
    .inc (up_xfer),
    .ptr (rr_ptr)
  );

  assign new_dest = rr_ptr;
  assign sel_bad  = 1'b0;
`else
  assign new_dest = bus.up_sel;

  // With N a power of two every index is in range.
  if ((1 << SELW) == N) begin : g_sel_full_range
    assign sel_bad = 1'b0;
  end else begin : g_sel_check
    assign sel_bad = (bus.up_sel >= SELW'(N));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      data_q    <= '0;
      dest_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= up_xfer && sel_bad;
      if (up_xfer && !sel_bad) begin
        // Load covers both EMPTY->FULL and the back-to-back FULL->FULL case.
        state  <= FULL;
        data_q <= bus.up_data;
        dest_q <= new_dest;
      end else if (dn_xfer) begin
        // A dropped word does not stop the held word from draining.
        state  <= EMPTY;
      end
    end
  end

  assign bus.up_ready  = up_ready;
  assign bus.dn_valid  = (state == FULL) ? (N'(1) << dest_q) : '0;
  assign bus.dn_data   = data_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux -- bench for stream_demux. Two instances (N=4 and N=3) see the
// same stimulus; a one-entry-queue reference model plus a delivered-word
// scoreboard checks both, and directed tables/sequences pin the corner cases.
// Honours STREAM_DEMUX_RR_EN when the design is built with it.
module tb_stream_demux;
  import stream_demux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .N(4)) if4 ();
  stream_demux_if #(.WIDTH(8), .N(3)) if3 ();

  stream_demux #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  stream_demux #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance is a one-entry queue: a held word with its channel.
  int          nch[2] = '{4, 3};
  bit          m_full[2];
  int          m_dest[2];
  logic [7:0]  m_data[2];
  bit          m_err[2];
  int          m_ptr[2];

  // Scoreboard of words still owed to the downstream side.
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];

  // Instance-0 outputs observed in the latest cycle, for table checks.
  logic        obs_ready;
  logic [3:0]  obs_valid;
  logic [7:0]  obs_data;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_dest[i] = 0; m_data[i] = '0; m_err[i] = 0; m_ptr[i] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] rdy);
    logic [3:0]  rdy_i;
    logic [31:0] a_ready, a_valid, a_err, a_data;
    logic [7:0]  exp_w;
    bit          e_ready, upx, dnx, bad;
    int          dst;
    @(negedge clk);
    if4.up_valid = v; if4.up_sel = sel; if4.up_data = d; if4.dn_ready = rdy;
    if3.up_valid = v; if3.up_sel = sel; if3.up_data = d; if3.dn_ready = rdy[2:0];
    #1;
    obs_ready = if4.up_ready;
    obs_valid = if4.dn_valid;
    obs_data  = if4.dn_data;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        rdy_i = rdy;
        a_ready = 32'(if4.up_ready); a_valid = 32'(if4.dn_valid);
        a_err = 32'(if4.sel_err); a_data = 32'(if4.dn_data);
      end else begin
        rdy_i = {1'b0, rdy[2:0]};
        a_ready = 32'(if3.up_ready); a_valid = 32'(if3.dn_valid);
        a_err = 32'(if3.sel_err); a_data = 32'(if3.dn_data);
      end
      e_ready = !m_full[i] || rdy_i[m_dest[i]];
      chk($sformatf("up_ready_n%0d", nch[i]), a_ready, e_ready ? 32'd1 : 32'd0);
      chk($sformatf("dn_valid_n%0d", nch[i]), a_valid, m_full[i] ? (32'd1 << m_dest[i]) : 32'd0);
      chk($sformatf("sel_err_n%0d", nch[i]), a_err, m_err[i] ? 32'd1 : 32'd0);
      if (m_full[i]) chk($sformatf("dn_data_n%0d", nch[i]), a_data, 32'(m_data[i]));
      // Scoreboard: every observed downstream transfer must deliver the oldest owed word.
      if ((a_valid & 32'(rdy_i)) != 0) begin
        if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          chk($sformatf("sb_unexpected_xfer_n%0d", nch[i]), 32'd1, 32'd0);
        end else begin
          exp_w = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("sb_data_n%0d", nch[i]), a_data, 32'(exp_w));
        end
      end
      // Advance the model across the coming rising edge.
      upx = v && e_ready;
      dnx = m_full[i] && rdy_i[m_dest[i]];
`ifdef STREAM_DEMUX_RR_EN
      dst = m_ptr[i];
      bad = 0;
      if (upx) m_ptr[i] = (m_ptr[i] + 1) % nch[i];
`else
      dst = int'(sel);
      bad = (int'(sel) >= nch[i]);
`endif
      m_err[i] = upx && bad;
      if (upx && !bad) begin
        m_full[i] = 1; m_dest[i] = dst; m_data[i] = d;
        if (i == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
      end else if (dnx) begin
        m_full[i] = 0;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    if4.up_valid = 0; if4.up_sel = '0; if4.up_data = '0; if4.dn_ready = '0;
    if3.up_valid = 0; if3.up_sel = '0; if3.up_data = '0; if3.dn_ready = '0;
    model_reset();

`ifdef STREAM_DEMUX_RR_EN
    // Round-robin: five words all asking for channel 0.
    tbl.push_back('{1'b1, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00});
    tbl.push_back('{1'b1, 2'd0, 8'h01, 4'hF, 1'b1, 4'b0001, 8'h00});
    tbl.push_back('{1'b1, 2'd0, 8'h02, 4'hF, 1'b1, 4'b0010, 8'h01});
    tbl.push_back('{1'b1, 2'd0, 8'h03, 4'hF, 1'b1, 4'b0100, 8'h02});
    tbl.push_back('{1'b1, 2'd0, 8'h04, 4'hF, 1'b1, 4'b1000, 8'h03});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0001, 8'h04});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00});
`else
    // Single word to channel 2.
    tbl.push_back('{1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, 4'b0000, 8'h00});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0100, 8'hA5});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00});
    // Backpressure on channel 1 for three cycles, then release.
    tbl.push_back('{1'b1, 2'd1, 8'h11, 4'hD, 1'b1, 4'b0000, 8'h00});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hD, 1'b0, 4'b0010, 8'h11});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hD, 1'b0, 4'b0010, 8'h11});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hD, 1'b0, 4'b0010, 8'h11});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0010, 8'h11});
    // Streaming to channels 0..3 without bubbles.
    tbl.push_back('{1'b1, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00});
    tbl.push_back('{1'b1, 2'd1, 8'h01, 4'hF, 1'b1, 4'b0001, 8'h00});
    tbl.push_back('{1'b1, 2'd2, 8'h02, 4'hF, 1'b1, 4'b0010, 8'h01});
    tbl.push_back('{1'b1, 2'd3, 8'h03, 4'hF, 1'b1, 4'b0100, 8'h02});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 8'h03});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00});
`endif

    // Reset values while rst is held.
    #8;
    chk("rst_state", 32'(if4.dbg_state), 32'(EMPTY));
    chk("rst_dn_valid", 32'(if4.dn_valid), 32'd0);
    chk("rst_dn_data", 32'(if4.dn_data), 32'd0);
    chk("rst_sel_err", 32'(if3.sel_err), 32'd0);
    chk("rst_up_ready", 32'(if4.up_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      cycle(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].rdy);
      chk($sformatf("tbl%0d_up_ready", k), 32'(obs_ready), 32'(tbl[k].exp_ready));
      chk($sformatf("tbl%0d_dn_valid", k), 32'(obs_valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid != 0)
        chk($sformatf("tbl%0d_dn_data", k), 32'(obs_data), 32'(tbl[k].exp_data));
    end

`ifndef STREAM_DEMUX_RR_EN
    // Out-of-range index on the N=3 instance: dropped, one-cycle sel_err.
    cycle(1'b1, 2'd3, 8'hFF, 4'hF);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);
    chk("badsel_dn_valid", 32'(if3.dn_valid), 32'd0);
    chk("badsel_err_pulse", 32'(if3.sel_err), 32'd1);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);
    chk("badsel_err_clear", 32'(if3.sel_err), 32'd0);
    chk("badsel_dn_valid2", 32'(if3.dn_valid), 32'd0);
`endif

    // Reset while holding 8'h5A for channel 3, mid-cycle with no clock edge.
    cycle(1'b1, 2'd3, 8'h5A, 4'h0);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);
`ifndef STREAM_DEMUX_RR_EN
    chk("rstmid_held_valid", 32'(obs_valid), 32'b1000);
    chk("rstmid_held_data", 32'(obs_data), 32'h5A);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_dn_valid_async", 32'(if4.dn_valid), 32'd0);
    chk("rstmid_up_ready", 32'(if4.up_ready), 32'd1);
    model_reset();
    // Upstream offers a word during reset; it must not be taken.
    @(negedge clk);
    if4.up_valid = 1; if4.up_sel = 2'd1; if4.up_data = 8'h77; if4.dn_ready = 4'hF;
    if3.up_valid = 1; if3.up_sel = 2'd1; if3.up_data = 8'h77; if3.dn_ready = 3'h7;
    @(negedge clk);
    rst = 1'b0;
    if4.up_valid = 0;
    if3.up_valid = 0;
    cycle(1'b0, 2'd0, 8'h00, 4'hF);
    chk("post_rst_no_xfer", 32'(obs_valid), 32'd0);
    cycle(1'b1, 2'd1, 8'h22, 4'hF);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);
`ifndef STREAM_DEMUX_RR_EN
    chk("post_rst_route_valid", 32'(obs_valid), 32'b0010);
`else
    chk("post_rst_route_valid", 32'(obs_valid), 32'b0001);
`endif
    chk("post_rst_route_data", 32'(obs_data), 32'h22);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) r = 4'hF;
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width in bits.
REQ-002 Parameter N, default 4, range 2..16, SHALL set the number of downstream channels.
REQ-003 Ports:
- clk  input  1  clock; all state SHALL update on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- up_valid  input  1  upstream word present.
- up_data  input  WIDTH  upstream word.
- up_sel  input  $clog2(N)  destination channel index.
- up_ready  output  1  upstream word accepted this cycle when up_valid is also high.
- dn_valid  output  N  one-hot; bit k marks the word offered to channel k.
- dn_data  output  WIDTH  word offered to the channel flagged in dn_valid, shared by all channels.
- dn_ready  input  N  per-channel consumer ready.
- sel_err  output  1  one-cycle pulse when a word with up_sel >= N is dropped.

Function
REQ-004 The block SHALL hold a single output register with data, destination index and state EMPTY or FULL.
REQ-005 An upstream transfer SHALL occur when up_valid && up_ready.
- up_ready = (state == EMPTY) || dn_ready[dest], combinational, with no dependence on up_valid.
REQ-006 A downstream transfer on channel k SHALL occur when dn_valid[k] && dn_ready[k].
REQ-007 dn_valid SHALL be all zeros in EMPTY.
- In FULL it SHALL have exactly bit dest set.
- dn_ready bits of other channels SHALL be ignored.
REQ-008 Latency from upstream transfer to dn_valid high SHALL be exactly 1 cycle.
REQ-009 State transitions:
- EMPTY -> FULL on an upstream transfer.
- FULL -> EMPTY on a downstream transfer without an upstream transfer.
- FULL -> FULL with the new word loaded on a simultaneous downstream and upstream transfer, giving full throughput of 1 word per cycle.
REQ-010 While FULL and dn_ready[dest] is low, data and dest SHALL remain stable and up_ready SHALL be low.
REQ-011 A word with up_sel >= N SHALL be accepted (up_ready as per REQ-005) and discarded.
- State SHALL be unchanged, except that a simultaneous downstream transfer still empties the register.
- sel_err SHALL pulse high the following cycle.
REQ-012 dn_data SHALL hold its last value in EMPTY; verification SHALL NOT check it there.

Reset
REQ-013 While rst is high the block SHALL hold:
- state EMPTY, dn_valid = 0, dn_data = 0, dest = 0, sel_err = 0.
- Round-robin pointer = 0 (when compiled in).
REQ-014 Asserting rst mid-transfer SHALL discard the held word without a downstream transfer.
REQ-015 up_ready SHALL be high during reset, but no transfer SHALL be recorded while rst is high.

Configuration
REQ-016 Macro STREAM_DEMUX_RR_EN:
- When defined, up_sel SHALL be ignored and the destination SHALL come from an internal pointer.
- The pointer SHALL start at 0 and increment by 1 modulo N on each upstream transfer.
- sel_err SHALL be tied to 0.
- When undefined, destination SHALL be up_sel as per REQ-011, and no pointer logic SHALL be present.

Structure
REQ-017 Package stream_demux_pkg SHALL contain:
- the state enum (EMPTY, FULL).
- constants DEFAULT_WIDTH = 8 and DEFAULT_N = 4.
REQ-018 Sub-module rr_pointer, a modulo-N counter with clk, rst, inc and ptr ports, SHALL be instantiated only under STREAM_DEMUX_RR_EN.

Verification (WIDTH=8, N=4)
REQ-019 Single word: up_sel=2, up_data=8'hA5, dn_ready=4'b1111 -> next cycle dn_valid=4'b0100 and dn_data=8'hA5; the cycle after, dn_valid=0.
REQ-020 Backpressure:
- Word 8'h11 to channel 1 with dn_ready=4'b1101 for 3 cycles -> dn_valid=4'b0010 and dn_data=8'h11 held stable, up_ready=0.
- Raising dn_ready[1] -> transfer, and up_ready=1 in the same cycle.
REQ-021 Streaming: sels 0,1,2,3 with data 8'h00..8'h03 on consecutive cycles, all ready -> dn_valid 0001, 0010, 0100, 1000 on consecutive cycles, no bubbles.
REQ-022 Bad select: N=3, up_sel=3, data 8'hFF -> dn_valid stays 0 and sel_err=1 for exactly one cycle.
REQ-023 Reset while FULL holding 8'h5A for channel 3 -> dn_valid=0 immediately, without waiting for clk; after release, the next word routes normally.
REQ-024 STREAM_DEMUX_RR_EN defined: 5 words with up_sel=0 -> dn_valid sequence 0001, 0010, 0100, 1000, 0001.
